// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit.
// Reset address, fetch stride, branch offset scaling and PC-select codes.
package pc_unit_pkg;

    localparam int          PC_WIDTH        = 32;
    localparam logic [31:0] PC_RESET        = 32'h0000_0000;
    localparam int          PC_INSTR_BYTES  = 4;
    localparam int          PC_OFFSET_SHIFT = 2;

    localparam logic PCSRC_SEQ    = 1'b0;
    localparam logic PCSRC_BRANCH = 1'b1;

endpackage

// File: rtl/pc_next_calc.sv
// Next fetch address: sequential PC+stride, or PC-relative branch target.
// Purely combinational; all arithmetic wraps modulo 2^WIDTH.
module pc_next_calc
    import pc_unit_pkg::*;
#(
    parameter int WIDTH        = PC_WIDTH,
    parameter int INSTR_BYTES  = PC_INSTR_BYTES,
    parameter int OFFSET_SHIFT = PC_OFFSET_SHIFT
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             pcsrc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_off;

    always_comb begin
        seq_pc = pc + WIDTH'(INSTR_BYTES);
        // Word offset to byte offset; top bits fall off by design.
        br_off = imm << OFFSET_SHIFT;
        case (pcsrc)
            PCSRC_BRANCH: next_pc = seq_pc + br_off;
            default:      next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with write enable and synchronous reset.
// PCin is the combinational next PC and is valid every cycle.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC     = WIDTH'(PC_RESET),
    parameter int               INSTR_BYTES  = PC_INSTR_BYTES,
    parameter int               OFFSET_SHIFT = PC_OFFSET_SHIFT
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWre,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] extendOut,
    output logic [WIDTH-1:0] PCin,
    output logic [WIDTH-1:0] PCout
);

    pc_next_calc #(
        .WIDTH        (WIDTH),
        .INSTR_BYTES  (INSTR_BYTES),
        .OFFSET_SHIFT (OFFSET_SHIFT)
    ) u_next (
        .pc      (PCout),
        .pcsrc   (PCSrc),
        .imm     (extendOut),
        .next_pc (PCin)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            PCout <= RESET_PC;
        end else if (PCWre) begin
            PCout <= PCin;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Randomized scoreboard bench for pc_unit against a behavioural PC model.
module tb_pc_unit;

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic        PCSrc;
    logic [31:0] extendOut;
    logic [31:0] PCin;
    logic [31:0] PCout;

    pc_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .extendOut (extendOut),
        .PCin      (PCin),
        .PCout     (PCout)
    );

    typedef struct {
        logic        chk_cur;
        logic [31:0] cur;
        logic [31:0] pcin;
        logic        chk_nxt;
        logic [31:0] nxt;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    logic [31:0] mpc   = 32'h0;
    logic        known = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model: a PC that advances by one instruction plus an optional
    // scaled word offset, 32-bit wrap, reset to zero.
    task automatic step(input logic r, input logic we, input logic src,
                        input logic [31:0] ext);
        item_t it;
        logic [31:0] target;
        @(negedge CLK);
        Reset     = r;
        PCWre     = we;
        PCSrc     = src;
        extendOut = ext;
        target  = mpc + 32'd4 + (src ? ext * 32'd4 : 32'd0);
        it.chk_cur = known;
        it.cur     = mpc;
        it.pcin    = target;
        if (r) mpc = 32'h0;
        else if (we) mpc = target;
        known      = known | r;
        it.chk_nxt = known;
        it.nxt     = mpc;
        q.push_back(it);
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge CLK);
            #2;
            if (q.size() != 0) begin
                it = q[0];
                if (it.chk_cur) begin
                    check("pcout_cur", PCout, it.cur);
                    check("pcin", PCin, it.pcin);
                end
                @(posedge CLK);
                #1;
                if (it.chk_nxt) check("pcout_next", PCout, it.nxt);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] e;
        Reset = 1'b1; PCWre = 1'b1; PCSrc = 1'b0; extendOut = 32'h0;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'd3);
        step(0, 1, 1, 32'hFFFF_FFFE);
        step(1, 1, 1, 32'd5);
        step(0, 1, 1, 32'd5);
        e = (32'hFFFF_FFF8 - mpc) >> 2;
        step(0, 1, 1, e);
        step(0, 1, 0, 32'h0);
        e = (32'hFFFF_FFF4 - mpc) >> 2;
        step(0, 1, 1, e);
        step(0, 1, 1, 32'd1);
        step(0, 0, 1, 32'h8000_0001);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ext;
            if ($urandom_range(0, 1) == 0)
                ext = 32'($urandom_range(0, 64)) - 32'd32;
            else
                ext = $urandom;
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), ext);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
        #3;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
